// File: rtl/ice_slave_arbiter_pkg.sv
// Shared definitions for the ice_bus slave arbiter.
// - Arbiter state encodings. The values match the ARB_* defines that legacy
//   Verilog code uses, so the state register reads the same in old and new dumps.
package ice_slave_arbiter_pkg;

  localparam int ARB_STATE_W = 2;

  localparam logic [ARB_STATE_W-1:0] ARB_IDLE    = 2'd0;
  localparam logic [ARB_STATE_W-1:0] ARB_GRANT   = 2'd1;
  localparam logic [ARB_STATE_W-1:0] ARB_RELEASE = 2'd2;

endpackage

// File: rtl/ice_slave_arbiter_pick.sv
// Combinational winner selection for ice_slave_arbiter.
// Ports:
//   req   in   NUM_DEV  eligible requests (already masked)
//   ptr   in   IDX_W    round-robin start index
//   mode  in   1        0 = round-robin from ptr, 1 = fixed priority (index 0 first)
//   win   out  NUM_DEV  one-hot winner, zero when req is zero
//   idx   out  IDX_W    winner index, zero when req is zero
module ice_arb_pick
  import ice_slave_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 7,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic [NUM_DEV-1:0] win,
  output logic [IDX_W-1:0]   idx
);

  // Scan NUM_DEV candidates starting at the start index and wrapping at
  // NUM_DEV-1, so non-power-of-two sizes never yield an index >= NUM_DEV.
  always_comb begin
    int   start;
    int   cand;
    logic found;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    start = mode ? 0 : int'(ptr);
    if (start >= NUM_DEV) start = 0;
    for (int k = 0; k < NUM_DEV; k++) begin
      cand = start + k;
      if (cand >= NUM_DEV) cand = cand - NUM_DEV;
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ice_slave_arbiter.sv
// Arbiter for the ice_bus slave output bus (sl_data/sl_addr/sl_tail).
// Grants one of NUM_DEV slave interfaces at a time, in round-robin or
// fixed-priority order, with a per-grant watchdog that revokes and locks out
// a slave that holds the bus too long.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   arb_mode         0 = round-robin, 1 = fixed priority (index 0 highest)
//   timeout_limit    max cycles per grant, 0 disables the watchdog
//   sl_arb_request   level request per slave, held for a whole frame
//   sl_arb_grant     registered one-hot (or zero) grant
//   grant_valid      any grant active
//   grant_idx        index of granted slave, 0 when none
//   tmo_pulse        one-cycle strobe when the watchdog revokes a grant
//   tmo_dev          index of the last revoked slave
//   tmo_mask         slaves locked out until they drop their request
module ice_slave_arbiter
  import ice_slave_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 7,
  parameter int IDX_W   = 3,
  parameter int TMO_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arb_mode,
  input  logic [TMO_W-1:0]   timeout_limit,
  input  logic [NUM_DEV-1:0] sl_arb_request,
  output logic [NUM_DEV-1:0] sl_arb_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               tmo_pulse,
  output logic [IDX_W-1:0]   tmo_dev,
  output logic [NUM_DEV-1:0] tmo_mask
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DEV - 1);

  logic [ARB_STATE_W-1:0] state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       rr_ptr;
  logic [TMO_W-1:0]       cnt;
  logic [TMO_W-1:0]       lim;

  logic [NUM_DEV-1:0] eligible;
  logic [NUM_DEV-1:0] pick_win;
  logic [IDX_W-1:0]   pick_idx;
  logic               req_held;
  logic               tmo_hit;

  assign eligible = sl_arb_request & ~tmo_mask;
  // The grant is one-hot, so this reads the owner's request bit.
  assign req_held = |(sl_arb_request & sl_arb_grant);
  assign tmo_hit  = (lim != '0) && (cnt == lim - TMO_W'(1));

  ice_arb_pick #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req  (eligible),
    .ptr  (rr_ptr),
    .mode (arb_mode),
    .win  (pick_win),
    .idx  (pick_idx)
  );

  assign grant_valid = |sl_arb_grant;
  // owner keeps the last winner through RELEASE for the pointer update;
  // the visible index is forced to zero whenever nothing is granted.
  assign grant_idx   = grant_valid ? owner : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      sl_arb_grant <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
      lim          <= '0;
      tmo_pulse    <= 1'b0;
      tmo_dev      <= '0;
      tmo_mask     <= '0;
    end else begin
      tmo_pulse <= 1'b0;
      // A lockout ends as soon as the slave lets go of its request.
      tmo_mask  <= tmo_mask & sl_arb_request;

      case (state)
        ARB_IDLE: begin
          if (|eligible) begin
            sl_arb_grant <= pick_win;
            owner        <= pick_idx;
            lim          <= timeout_limit;
            cnt          <= '0;
            state        <= ARB_GRANT;
          end
        end

        ARB_GRANT: begin
          if (cnt != '1) cnt <= cnt + TMO_W'(1);
          // A request drop wins over a coincident watchdog expiry.
          if (!req_held) begin
            sl_arb_grant <= '0;
            state        <= ARB_RELEASE;
          end else if (tmo_hit) begin
            sl_arb_grant <= '0;
            tmo_pulse    <= 1'b1;
            tmo_dev      <= owner;
            tmo_mask     <= (tmo_mask & sl_arb_request) | sl_arb_grant;
            state        <= ARB_RELEASE;
          end
        end

        // One idle bus cycle so two grants can never touch.
        ARB_RELEASE: begin
          rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
          cnt    <= '0;
          state  <= ARB_IDLE;
        end

        default: begin
          sl_arb_grant <= '0;
          state        <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
